// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage between the control unit and the
// data bus. Accepts single-cycle load/store requests, runs the read or write
// handshake, steers byte lanes and extends load data.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses skip the bus and complete with
//               misaligned=1 (load_dout=0 for loads)
//   undefined : offending low address bits are ignored, misaligned stays 0
//
// Ports:
//   clk, rst (sync, active-low)
//   load_data, store_data      request pulses from the control unit
//   mem_addr, mem_size, mem_unsigned, store_din   request payload
//   data_valid, load_dout, misaligned             completion to control unit
//   dr_addr_valid/ready, dr_addr                  read address channel
//   dr_data_valid/ready, dr_data                  read data channel
//   dw_valid/ready, dw_addr, dw_data, dw_strobe   write request channel
//   dw_resp_valid/ready                           write response channel
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_data,
  input  logic                  store_data,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           store_din,
  output logic                  data_valid,
  output logic [31:0]           load_dout,
  output logic                  misaligned,
  output logic                  dr_addr_valid,
  input  logic                  dr_addr_ready,
  output logic [ADDR_WIDTH-1:0] dr_addr,
  input  logic                  dr_data_valid,
  output logic                  dr_data_ready,
  input  logic [31:0]           dr_data,
  output logic                  dw_valid,
  input  logic                  dw_ready,
  output logic [ADDR_WIDTH-1:0] dw_addr,
  output logic [31:0]           dw_data,
  output logic [3:0]            dw_strobe,
  input  logic                  dw_resp_valid,
  output logic                  dw_resp_ready
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LANES      = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            addr_lo_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  accept_c;
  logic                  misalign_c;
  logic [4:0]            shamt_c;
  logic [DATA_WIDTH-1:0] shifted_c;
  logic [DATA_WIDTH-1:0] ext_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [LANES-1:0]      wr_strobe_c;

  assign accept_c = (state == IDLE) && (load_data || store_data);

  // Alignment check on the incoming request
  always_comb begin
    misalign_c = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (mem_size)
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = mem_addr[0];
      default: misalign_c = |mem_addr[1:0];
    endcase
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_data || store_data) begin
          if (misalign_c)     state_nxt = DONE;
          else if (load_data) state_nxt = RD_ADDR;
          else                state_nxt = WR_REQ;
        end
      end
      RD_ADDR: if (dr_addr_ready) state_nxt = RD_DATA;
      RD_DATA: if (dr_data_valid) state_nxt = DONE;
      WR_REQ:  if (dw_ready)      state_nxt = WR_RESP;
      WR_RESP: if (dw_resp_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load path: shift the addressed lane down, then extend; half/word ignore
  // the low bits that a misaligned access would otherwise select
  always_comb begin
    case (size_q)
      2'b00:   shamt_c = {addr_lo_q, 3'b000};
      2'b01:   shamt_c = {addr_lo_q[1], 4'b0000};
      default: shamt_c = 5'd0;
    endcase
    shifted_c = dr_data >> shamt_c;
    case (size_q)
      2'b00:   ext_c = unsigned_q ? {24'h0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ext_c = unsigned_q ? {16'h0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Store path: replicate data across lanes, strobe selects the live ones
  always_comb begin
    case (mem_size)
      2'b00: begin
        wr_data_c   = {4{store_din[7:0]}};
        wr_strobe_c = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        wr_data_c   = {2{store_din[15:0]}};
        wr_strobe_c = 4'b0011 << {mem_addr[1], 1'b0};
      end
      default: begin
        wr_data_c   = store_din;
        wr_strobe_c = 4'b1111;
      end
    endcase
  end

  // State register and captured request attributes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_lo_q  <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        addr_lo_q  <= mem_addr[1:0];
        size_q     <= mem_size;
        unsigned_q <= mem_unsigned;
      end
    end
  end

  // Registered outputs; handshake flags follow the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_valid    <= 1'b0;
      misaligned    <= 1'b0;
      load_dout     <= '0;
      dr_addr_valid <= 1'b0;
      dr_addr       <= '0;
      dr_data_ready <= 1'b0;
      dw_valid      <= 1'b0;
      dw_addr       <= '0;
      dw_data       <= '0;
      dw_strobe     <= '0;
      dw_resp_ready <= 1'b0;
    end else begin
      dr_addr_valid <= (state_nxt == RD_ADDR);
      dr_data_ready <= (state_nxt == RD_DATA);
      dw_valid      <= (state_nxt == WR_REQ);
      dw_resp_ready <= (state_nxt == WR_RESP);
      data_valid    <= (state_nxt == DONE);
      misaligned    <= accept_c && misalign_c;
      if (accept_c && load_data && !misalign_c)
        dr_addr <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
      if (accept_c && !load_data && !misalign_c) begin
        dw_addr   <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
        dw_data   <= wr_data_c;
        dw_strobe <= wr_strobe_c;
      end
      if (state == RD_DATA && dr_data_valid)
        load_dout <= ext_c;
      else if (accept_c && load_data && misalign_c)
        load_dout <= '0;
    end
  end

endmodule
